// File: rtl/blast_core.sv
// rtl/blast_core.sv - accumulator core with fetch/decode/execute FSM and single-port program memory
module blast_core #(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    prog_we,
  input  logic [ADDRESS_BITS-1:0] prog_addr,
  input  logic [DATA_BITS-1:0]    prog_data,
  output logic [DATA_BITS-1:0]    acc_out,
  output logic [ADDRESS_BITS-1:0] pc_out,
  output logic [1:0]              state_out,
  output logic                    halted,
  output logic                    zero,
  output logic                    carry
);

  // IR keeps only the opcode and operand fields; the bits between them are don't-care
  localparam int IR_BITS = ADDRESS_BITS + 3;
  localparam int DEPTH   = 2 ** ADDRESS_BITS;

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_STA = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;

  localparam logic [ADDRESS_BITS-1:0] PC_ONE = {{(ADDRESS_BITS-1){1'b0}}, 1'b1};

  logic [DATA_BITS-1:0]    mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [IR_BITS-1:0]      ir_q, ir_d;
  logic [DATA_BITS-1:0]    mdr_q, mdr_d;
  logic [DATA_BITS-1:0]    acc_q, acc_d;
  logic                    zero_q, zero_d;
  logic                    carry_q, carry_d;

  logic [2:0]              opcode;
  logic [ADDRESS_BITS-1:0] operand;
  logic                    prog_wr;
  logic                    core_wr;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0]    mem_wdata;
  logic [DATA_BITS-1:0]    mem_rdata;
  logic [DATA_BITS:0]      sum;
  logic [DATA_BITS:0]      diff;

  assign opcode  = ir_q[IR_BITS-1 -: 3];
  assign operand = ir_q[ADDRESS_BITS-1:0];

  // Loader owns the single memory port whenever the core is stalled or halted
  assign prog_wr   = prog_we && (!enable || state_q == S_HALT);
  assign core_wr   = enable && state_q == S_EXECUTE && opcode == OP_STA;
  // A store caught by reset is abandoned, so the core write is gated by reset itself
  assign mem_we    = prog_wr || (core_wr && reset);
  assign mem_addr  = prog_wr ? prog_addr : ((state_q == S_FETCH) ? pc_q : operand);
  assign mem_wdata = prog_wr ? prog_data : acc_q;
  assign mem_rdata = mem[mem_addr];

  assign sum  = {1'b0, acc_q} + {1'b0, mdr_q};
  assign diff = {1'b0, acc_q} - {1'b0, mdr_q};

  // Next-state and datapath update for one enabled cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (enable) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = {mem_rdata[DATA_BITS-1 -: 3], mem_rdata[ADDRESS_BITS-1:0]};
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          mdr_d   = mem_rdata;
          state_d = S_EXECUTE;
        end
        S_EXECUTE: begin
          state_d = S_FETCH;
          case (opcode)
            OP_NOP, OP_STA: ;
            OP_LDA: begin
              acc_d  = mdr_q;
              zero_d = (mdr_q == '0);
            end
            OP_ADD: begin
              {carry_d, acc_d} = sum;
              zero_d           = (sum[DATA_BITS-1:0] == '0);
            end
            OP_SUB: begin
              acc_d   = diff[DATA_BITS-1:0];
              carry_d = diff[DATA_BITS];
              zero_d  = (diff[DATA_BITS-1:0] == '0);
            end
            OP_JMP: pc_d = operand;
            OP_JZ:  if (zero_q) pc_d = operand;
            default: state_d = S_HALT;
          endcase
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  // Architectural registers; reset forces them immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign state_out = state_q;
  assign halted    = (state_q == S_HALT);
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_blast_core.sv
// tb/tb_blast_core.sv - directed-vector bench for blast_core
module tb_blast_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] acc_out;
  logic [4:0] pc_out;
  logic [1:0] state_out;
  logic       halted;
  logic       zero;
  logic       carry;

  int vec_cnt = 0;
  int err_cnt = 0;

  blast_core #(.DATA_BITS(8), .ADDRESS_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .state_out (state_out),
    .halted    (halted),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    run(1);
    prog_we   = 1'b0;
  endtask

  task automatic apply_reset();
    enable  = 1'b0;
    prog_we = 1'b0;
    #2 reset = 1'b0;
    run(1);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values appear without a clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_state", state_out, 2'b00);
    chk("rst_pc", pc_out, 5'h00);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_carry", carry, 1'b0);
    run(1);
    reset = 1'b1;

    // Add-and-store with a 5-cycle stall in DECODE
    load(5'h00, 8'h30); load(5'h01, 8'h71); load(5'h02, 8'h52); load(5'h03, 8'hE0);
    load(5'h10, 8'h05); load(5'h11, 8'h07);
    enable = 1'b1;
    run(4);
    chk("t1_decode_state", state_out, 2'b01);
    chk("t1_decode_pc", pc_out, 5'h02);
    enable = 1'b0;
    run(5);
    chk("stall_state", state_out, 2'b01);
    chk("stall_pc", pc_out, 5'h02);
    chk("stall_acc", acc_out, 8'h05);
    chk("stall_halted", halted, 1'b0);
    enable = 1'b1;
    run(8);
    chk("t1_acc", acc_out, 8'h0C);
    chk("t1_halted", halted, 1'b1);
    chk("t1_state", state_out, 2'b11);
    chk("t1_pc", pc_out, 5'h04);
    chk("t1_zero", zero, 1'b0);
    chk("t1_carry", carry, 1'b0);
    run(4);
    chk("halt_hold_state", state_out, 2'b11);
    chk("halt_hold_pc", pc_out, 5'h04);
    // Loads accepted while halted even with enable high; read mem[12] back
    load(5'h00, 8'h32); load(5'h01, 8'hE0);
    apply_reset();
    enable = 1'b1;
    run(6);
    chk("t1_mem12", acc_out, 8'h0C);
    chk("t1_rb_halted", halted, 1'b1);
    chk("t1_rb_pc", pc_out, 5'h02);

    // Carry and borrow
    apply_reset();
    load(5'h00, 8'h30); load(5'h01, 8'h71); load(5'h02, 8'h92); load(5'h03, 8'h93);
    load(5'h04, 8'hE0);
    load(5'h10, 8'hF0); load(5'h11, 8'h20); load(5'h12, 8'h10); load(5'h13, 8'h01);
    enable = 1'b1;
    run(3);
    chk("t2_lda_acc", acc_out, 8'hF0);
    run(3);
    chk("t2_add_acc", acc_out, 8'h10);
    chk("t2_add_carry", carry, 1'b1);
    chk("t2_add_zero", zero, 1'b0);
    run(3);
    chk("t2_sub_acc", acc_out, 8'h00);
    chk("t2_sub_zero", zero, 1'b1);
    chk("t2_sub_carry", carry, 1'b0);
    run(3);
    chk("t2_borrow_acc", acc_out, 8'hFF);
    chk("t2_borrow_carry", carry, 1'b1);
    chk("t2_borrow_zero", zero, 1'b0);
    run(3);
    chk("t2_halted", halted, 1'b1);

    // Branches, wrap, and ignored loads while running
    apply_reset();
    load(5'h00, 8'h30); load(5'h01, 8'hC5); load(5'h05, 8'h31); load(5'h06, 8'hCA);
    load(5'h07, 8'hBF); load(5'h1F, 8'hBF); load(5'h10, 8'h00); load(5'h11, 8'h01);
    enable = 1'b1;
    run(3);
    chk("t3_zero_set", zero, 1'b1);
    run(3);
    chk("t3_jz_taken_pc", pc_out, 5'h05);
    run(3);
    chk("t3_zero_clr", zero, 1'b0);
    chk("t3_lda_pc", pc_out, 5'h06);
    run(3);
    chk("t3_jz_not_taken_pc", pc_out, 5'h07);
    run(3);
    chk("t3_jmp_pc", pc_out, 5'h1F);
    run(1);
    chk("t3_fetch_wrap_pc", pc_out, 5'h00);
    run(2);
    chk("t3_jmp_loop_pc", pc_out, 5'h1F);
    chk("t3_jmp_loop_state", state_out, 2'b00);
    prog_addr = 5'h1F;
    prog_data = 8'h00;
    prog_we   = 1'b1;
    run(3);
    prog_we   = 1'b0;
    chk("t3_ignored_load_pc", pc_out, 5'h1F);
    enable = 1'b0;
    load(5'h1F, 8'h00);
    enable = 1'b1;
    run(3);
    chk("t3_nop_wrap_pc", pc_out, 5'h00);

    // Reset during EXECUTE of STA
    apply_reset();
    load(5'h00, 8'h30); load(5'h01, 8'h52); load(5'h10, 8'hAA); load(5'h12, 8'h33);
    enable = 1'b1;
    run(5);
    chk("t4_exec_state", state_out, 2'b10);
    chk("t4_exec_acc", acc_out, 8'hAA);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_acc", acc_out, 8'h00);
    chk("t4_async_pc", pc_out, 5'h00);
    chk("t4_async_state", state_out, 2'b00);
    run(1);
    reset = 1'b1;
    run(3);
    chk("t4_restart_pc", pc_out, 5'h01);
    chk("t4_restart_acc", acc_out, 8'hAA);
    enable = 1'b0;
    load(5'h01, 8'h32); load(5'h02, 8'hE0);
    enable = 1'b1;
    run(6);
    chk("t4_mem12_kept", acc_out, 8'h33);
    chk("t4_halted", halted, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
